alu_multicycle: RTL and testbench
=================================

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; SHALL be a power of two, >= 8.
REQ-002 Port: clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: alu_op  input  4  operation code (encoding per REQ-012).
REQ-005 Port: operand_a, operand_b  input  WIDTH  signed operands.
REQ-006 Port: in_valid  input  1 / in_ready  output  1  request handshake.
REQ-007 Port: out_valid  output  1 / out_ready  input  1  response handshake.
REQ-008 Port: result  output  WIDTH  registered result.
REQ-009 Port: result_zero, result_negative, result_carry, result_overflow  output  1 each  registered flags.

Function
REQ-010 FSM states IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-011 Accept = in_valid & in_ready; on accept, alu_op and operands SHALL be captured; inputs outside IDLE SHALL be ignored.
REQ-012 Ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL (low WIDTH bits), 11 MULH (signed x signed, high WIDTH bits), 12 DIV (signed), 13 REM (signed); 14, 15 SHALL behave as ADD.
REQ-013 Shift amount SHALL be operand_b[$clog2(WIDTH)-1:0]; upper bits ignored.
REQ-014 SLT/SLTU result SHALL be 1 or 0 zero-extended to WIDTH.
REQ-015 Ops 0-9, 14, 15: IDLE -> DONE on accept; out_valid SHALL assert the cycle after accept (latency 1).
REQ-016 Ops 10-13: IDLE -> BUSY on accept; BUSY SHALL last exactly WIDTH cycles (down-counter), then -> DONE; out_valid asserts WIDTH+1 cycles after accept.
REQ-017 Iterative algorithm (shift-add / restoring divide) is implementer's choice; cycle count per REQ-016 is fixed, independent of operand values.
REQ-018 DIV by zero: quotient all-ones; REM by zero: operand_a.
REQ-019 Signed overflow (most-negative / -1): DIV result most-negative value, REM result 0.
REQ-020 DIV truncates toward zero; REM sign follows operand_a.
REQ-021 result_zero = (result == 0); result_negative = result[WIDTH-1]; both for every op.
REQ-022 ADD: carry = unsigned carry-out, overflow = signed overflow; SUB: carry = 1 when a >= b unsigned (no borrow), overflow = signed overflow; all other ops: carry = 0, overflow = 0.
REQ-023 DONE: result and flags SHALL hold stable until out_ready = 1; on out_valid & out_ready -> IDLE next cycle.
REQ-024 Minimum spacing between back-to-back single-cycle ops SHALL be 2 cycles (accept, DONE/handshake).
REQ-025 result and flags SHALL change only on the transition into DONE or on reset.

Reset
REQ-026 reset = 1 SHALL force state IDLE, counter 0, result 0, all flags 0, out_valid 0, in_ready 1 on the next edge.
REQ-027 Reset has priority over accept and handshake; reset during BUSY or DONE SHALL discard the operation with no out_valid pulse.

Verification (WIDTH = 32)
REQ-028 ADD 0x7FFFFFFF + 0x00000001 -> one cycle later out_valid = 1, result 0x80000000, negative 1, overflow 1, carry 0, zero 0.
REQ-029 SUB 5 - 5 -> result 0, zero 1, carry 1, overflow 0; SRA 0x80000000 by operand_b = 33 -> 0xC0000000.
REQ-030 MUL -3 x 7 -> 0xFFFFFFEB; MULH same operands -> 0xFFFFFFFF; out_valid exactly 33 cycles after accept, in_ready 0 throughout.
REQ-031 DIV 7 / 0 -> 0xFFFFFFFF; REM 7 / 0 -> 7; DIV 0x80000000 / -1 -> 0x80000000; REM same -> 0; DIV -7 / 2 -> -3, REM -> -1.
REQ-032 Backpressure: hold out_ready = 0 for 5 cycles in DONE with in_valid = 1 and new operands -> result/flags stable, in_ready 0, new request not accepted; accepted only after handshake completes.
REQ-033 Assert reset on 10th BUSY cycle of a DIV -> next cycle out_valid 0, in_ready 1, result 0, no later out_valid; subsequent ADD 2 + 3 -> 5.

Source files
------------

// File: rtl/alu_multicycle.sv
// alu_multicycle: registered ALU with a one-cycle path for simple ops and a
// fixed WIDTH-cycle iterative path for MUL/MULH/DIV/REM.
//
// Handshake semantics: a request is accepted on a rising edge where
// in_valid & in_ready are both 1 (in_ready is 1 only in IDLE); a response
// completes on a rising edge where out_valid & out_ready are both 1
// (out_valid is 1 only in DONE). Request inputs are ignored while in_ready
// is 0, and result/flags hold until the response handshake completes.
module alu_multicycle #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             result_zero,
   output logic             result_negative,
   output logic             result_carry,
   output logic             result_overflow,
   output logic [1:0]       state_dbg
);

   localparam int SHW  = $clog2(WIDTH);
   localparam int CNTW = $clog2(WIDTH) + 1;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLL  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_SRA  = 4'd7;
   localparam logic [3:0] OP_SLT  = 4'd8;
   localparam logic [3:0] OP_SLTU = 4'd9;
   localparam logic [3:0] OP_MUL  = 4'd10;
   localparam logic [3:0] OP_MULH = 4'd11;
   localparam logic [3:0] OP_DIV  = 4'd12;
   localparam logic [3:0] OP_REM  = 4'd13;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   logic [CNTW-1:0]   count;
   logic [3:0]        op_q;
   logic [WIDTH-1:0]  a_q, b_q;
   // MUL: {acc_hi, acc_lo} is the partial product with the multiplier
   // shifting out of acc_lo. DIV/REM: acc_hi is the partial remainder and
   // acc_lo shifts the dividend out while the quotient shifts in.
   logic [WIDTH-1:0]  acc_hi, acc_lo;

   logic [WIDTH:0]    add_sum;
   logic [WIDTH-1:0]  sub_diff;
   logic [SHW-1:0]    shamt;
   logic [WIDTH-1:0]  alu_res;
   logic              alu_carry, alu_ovf;
   logic              is_multi, is_mul_in;
   logic [WIDTH-1:0]  mag_a_in, mag_b_in;

   logic [WIDTH-1:0]   mag_a_q, mag_b_q;
   logic [WIDTH:0]     mul_sum, div_trial, div_diff;
   logic [WIDTH-1:0]   step_hi, step_lo;
   logic [2*WIDTH-1:0] prod, prod_signed;
   logic [WIDTH-1:0]   quo_signed, rem_signed, iter_res;
   logic               is_mul_q;

   assign state_dbg = state;

   // Single-cycle ALU on the live request inputs, plus operand magnitudes for the iterative path
   always_comb begin
      add_sum   = {1'b0, operand_a} + {1'b0, operand_b};
      sub_diff  = operand_a - operand_b;
      shamt     = operand_b[SHW-1:0];
      alu_res   = add_sum[WIDTH-1:0];
      alu_carry = 1'b0;
      alu_ovf   = 1'b0;
      case (alu_op)
         OP_SUB: begin
            alu_res   = sub_diff;
            alu_carry = (operand_a >= operand_b);
            alu_ovf   = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                        (sub_diff[WIDTH-1] != operand_a[WIDTH-1]);
         end
         OP_AND:  alu_res = operand_a & operand_b;
         OP_OR:   alu_res = operand_a | operand_b;
         OP_XOR:  alu_res = operand_a ^ operand_b;
         OP_SLL:  alu_res = operand_a << shamt;
         OP_SRL:  alu_res = operand_a >> shamt;
         OP_SRA:  alu_res = $signed(operand_a) >>> shamt;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, operand_a < operand_b};
         default: begin
            // ADD, and codes 14/15 which alias ADD
            alu_carry = add_sum[WIDTH];
            alu_ovf   = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                        (add_sum[WIDTH-1] != operand_a[WIDTH-1]);
         end
      endcase
      is_multi  = (alu_op >= OP_MUL) && (alu_op <= OP_REM);
      is_mul_in = (alu_op == OP_MUL) || (alu_op == OP_MULH);
      mag_a_in  = operand_a[WIDTH-1] ? -operand_a : operand_a;
      mag_b_in  = operand_b[WIDTH-1] ? -operand_b : operand_b;
   end

   // One shift-add / restoring-divide step on unsigned magnitudes, then sign fix-up of the final step
   always_comb begin
      is_mul_q  = (op_q == OP_MUL) || (op_q == OP_MULH);
      mag_a_q   = a_q[WIDTH-1] ? -a_q : a_q;
      mag_b_q   = b_q[WIDTH-1] ? -b_q : b_q;
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a_q} : {(WIDTH+1){1'b0}});
      div_trial = {acc_hi, acc_lo[WIDTH-1]};
      div_diff  = div_trial - {1'b0, mag_b_q};
      if (is_mul_q) begin
         step_hi = mul_sum[WIDTH:1];
         step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
      end else if (!div_diff[WIDTH]) begin
         step_hi = div_diff[WIDTH-1:0];
         step_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
         step_hi = div_trial[WIDTH-1:0];
         step_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
      prod        = {step_hi, step_lo};
      prod_signed = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -prod : prod;
      // most-negative / -1 falls out naturally: magnitude quotient 2^(WIDTH-1), remainder 0
      quo_signed  = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -step_lo : step_lo;
      rem_signed  = a_q[WIDTH-1] ? -step_hi : step_hi;
      case (op_q)
         OP_MUL:  iter_res = prod_signed[WIDTH-1:0];
         OP_MULH: iter_res = prod_signed[2*WIDTH-1:WIDTH];
         OP_DIV:  iter_res = (b_q == '0) ? {WIDTH{1'b1}} : quo_signed;
         default: iter_res = (b_q == '0) ? a_q : rem_signed;
      endcase
   end

   // Control FSM, operand capture, iteration registers and registered result/flags
   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= IDLE;
         in_ready        <= 1'b1;
         out_valid       <= 1'b0;
         count           <= '0;
         op_q            <= '0;
         a_q             <= '0;
         b_q             <= '0;
         acc_hi          <= '0;
         acc_lo          <= '0;
         result          <= '0;
         result_zero     <= 1'b0;
         result_negative <= 1'b0;
         result_carry    <= 1'b0;
         result_overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  op_q     <= alu_op;
                  a_q      <= operand_a;
                  b_q      <= operand_b;
                  in_ready <= 1'b0;
                  if (is_multi) begin
                     state  <= BUSY;
                     count  <= CNTW'(WIDTH);
                     acc_hi <= '0;
                     acc_lo <= is_mul_in ? mag_b_in : mag_a_in;
                  end else begin
                     state           <= DONE;
                     out_valid       <= 1'b1;
                     result          <= alu_res;
                     result_zero     <= (alu_res == '0);
                     result_negative <= alu_res[WIDTH-1];
                     result_carry    <= alu_carry;
                     result_overflow <= alu_ovf;
                  end
               end
            end
            BUSY: begin
               acc_hi <= step_hi;
               acc_lo <= step_lo;
               count  <= count - CNTW'(1);
               if (count == CNTW'(1)) begin
                  state           <= DONE;
                  out_valid       <= 1'b1;
                  result          <= iter_res;
                  result_zero     <= (iter_res == '0);
                  result_negative <= iter_res[WIDTH-1];
                  result_carry    <= 1'b0;
                  result_overflow <= 1'b0;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed and random checks of alu_multicycle (WIDTH = 32)
// with a result/flags scoreboard queue.
`timescale 1ns/1ps
module tb_alu_multicycle;

   localparam int W = 32;
   localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;

   logic         clock;
   logic         reset;
   logic [3:0]   alu_op;
   logic [W-1:0] operand_a, operand_b;
   logic         in_valid, in_ready;
   logic         out_valid, out_ready;
   logic [W-1:0] result;
   logic         result_zero, result_negative, result_carry, result_overflow;
   logic [1:0]   state_dbg;

   // {zero, negative, carry, overflow, result}
   logic [W+3:0] exp_q[$];

   typedef struct {
      logic [3:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [3:0]   flags;
      logic [W-1:0] res;
      int           lat;
   } vec_t;
   vec_t dir_tab[$];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   alu_multicycle #(.WIDTH(W)) dut (
      .clock(clock), .reset(reset), .alu_op(alu_op),
      .operand_a(operand_a), .operand_b(operand_b),
      .in_valid(in_valid), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .result_zero(result_zero),
      .result_negative(result_negative), .result_carry(result_carry),
      .result_overflow(result_overflow), .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [W+3:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
      logic [W:0] s;
      logic [W-1:0] r;
      logic c, v;
      logic signed [2*W-1:0] sa, sb, p;
      c  = 1'b0;
      v  = 1'b0;
      sa = $signed(a);
      sb = $signed(b);
      p  = sa * sb;
      s  = {1'b0, a} + {1'b0, b};
      r  = s[W-1:0];
      case (op)
         4'd1: begin
            r = a - b;
            c = (a >= b);
            v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
         end
         4'd2:  r = a & b;
         4'd3:  r = a | b;
         4'd4:  r = a ^ b;
         4'd5:  r = a << b[4:0];
         4'd6:  r = a >> b[4:0];
         4'd7:  r = $signed(a) >>> b[4:0];
         4'd8:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd9:  r = (a < b) ? 32'd1 : 32'd0;
         4'd10: r = p[W-1:0];
         4'd11: r = p[2*W-1:W];
         4'd12: begin
            if (b == 0) r = 32'hFFFF_FFFF;
            else if (a == MIN_NEG && b == 32'hFFFF_FFFF) r = MIN_NEG;
            else r = $signed(a) / $signed(b);
         end
         4'd13: begin
            if (b == 0) r = a;
            else if (a == MIN_NEG && b == 32'hFFFF_FFFF) r = 0;
            else r = $signed(a) % $signed(b);
         end
         default: begin
            c = s[W];
            v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
         end
      endcase
      return {(r == 0), r[W-1], c, v, r};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive_req(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int n;
      n         = 0;
      alu_op    = op;
      operand_a = a;
      operand_b = b;
      in_valid  = 1'b1;
      while (!in_ready && n < 200) begin
         @(posedge clock); #1;
         n++;
      end
      @(posedge clock); #1;
      in_valid = 1'b0;
   endtask

   // Waits for out_valid (latency counted from the accept cycle), captures, then handshakes.
   task automatic collect_resp(output logic [W+3:0] got, output int lat,
                               output bit saw_ready, output bit timed_out);
      lat       = 1;
      saw_ready = 1'b0;
      while (!out_valid && lat < 200) begin
         if (in_ready) saw_ready = 1'b1;
         @(posedge clock); #1;
         lat++;
      end
      timed_out = !out_valid;
      got = {result_zero, result_negative, result_carry, result_overflow, result};
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
   endtask

   task automatic add_vec(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] flags, input logic [W-1:0] res, input int lat);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.flags = flags; v.res = res; v.lat = lat;
      dir_tab.push_back(v);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      reset     = 1'b1;
      in_valid  = 1'b1;
      alu_op    = 4'd0;
      operand_a = 32'd1;
      operand_b = 32'd1;
      out_ready = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_hs: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
      end
      n_checks++;
      if ({result_zero, result_negative, result_carry, result_overflow, result} !== '0) begin
         n_fail++;
         $display("FAIL reset_result: got %h flags %b%b%b%b, want all zero", result,
                  result_zero, result_negative, result_carry, result_overflow);
      end
      in_valid = 1'b0;
      reset    = 1'b0;
      @(posedge clock); #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_priority: out_valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_directed;
      logic [W+3:0] got, exp;
      int lat;
      bit saw_ready, to;
      add_vec(4'd0,  32'h7FFF_FFFF, 32'h1,         4'b0101, 32'h8000_0000, 1);
      add_vec(4'd0,  32'hFFFF_FFFF, 32'h1,         4'b1010, 32'h0,         1);
      add_vec(4'd1,  32'd5,         32'd5,         4'b1010, 32'h0,         1);
      add_vec(4'd1,  32'd3,         32'd5,         4'b0100, 32'hFFFF_FFFE, 1);
      add_vec(4'd1,  32'h8000_0000, 32'h1,         4'b0011, 32'h7FFF_FFFF, 1);
      add_vec(4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0100, 32'hF000_F000, 1);
      add_vec(4'd3,  32'h0F0F_0000, 32'h0000_00F0, 4'b0000, 32'h0F0F_00F0, 1);
      add_vec(4'd4,  32'hAAAA_AAAA, 32'hAAAA_AAAA, 4'b1000, 32'h0,         1);
      add_vec(4'd5,  32'h1,         32'd31,        4'b0100, 32'h8000_0000, 1);
      add_vec(4'd5,  32'h3,         32'd33,        4'b0000, 32'h6,         1);
      add_vec(4'd6,  32'h8000_0000, 32'd31,        4'b0000, 32'h1,         1);
      add_vec(4'd7,  32'h8000_0000, 32'd33,        4'b0100, 32'hC000_0000, 1);
      add_vec(4'd8,  32'hFFFF_FFFF, 32'h1,         4'b0000, 32'h1,         1);
      add_vec(4'd9,  32'hFFFF_FFFF, 32'h1,         4'b1000, 32'h0,         1);
      add_vec(4'd14, 32'd2,         32'd3,         4'b0000, 32'd5,         1);
      add_vec(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0110, 32'hFFFF_FFFE, 1);
      add_vec(4'd10, 32'hFFFF_FFFD, 32'd7,         4'b0100, 32'hFFFF_FFEB, 33);
      add_vec(4'd11, 32'hFFFF_FFFD, 32'd7,         4'b0100, 32'hFFFF_FFFF, 33);
      add_vec(4'd10, 32'h8000_0000, 32'h8000_0000, 4'b1000, 32'h0,         33);
      add_vec(4'd11, 32'h8000_0000, 32'h8000_0000, 4'b0000, 32'h4000_0000, 33);
      add_vec(4'd12, 32'd7,         32'd0,         4'b0100, 32'hFFFF_FFFF, 33);
      add_vec(4'd13, 32'd7,         32'd0,         4'b0000, 32'd7,         33);
      add_vec(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 4'b0100, 32'h8000_0000, 33);
      add_vec(4'd13, 32'h8000_0000, 32'hFFFF_FFFF, 4'b1000, 32'h0,         33);
      add_vec(4'd12, 32'hFFFF_FFF9, 32'd2,         4'b0100, 32'hFFFF_FFFD, 33);
      add_vec(4'd13, 32'hFFFF_FFF9, 32'd2,         4'b0100, 32'hFFFF_FFFF, 33);
      add_vec(4'd12, 32'd100,       32'hFFFF_FFF9, 4'b0100, 32'hFFFF_FFF2, 33);
      add_vec(4'd13, 32'd100,       32'hFFFF_FFF9, 4'b0000, 32'd2,         33);
      foreach (dir_tab[i]) begin
         drive_req(dir_tab[i].op, dir_tab[i].a, dir_tab[i].b);
         exp_q.push_back({dir_tab[i].flags, dir_tab[i].res});
         collect_resp(got, lat, saw_ready, to);
         exp = exp_q.pop_front();
         n_checks++;
         if (to) begin
            n_fail++;
            $display("FAIL dir_timeout[%0d]: op=%0d no out_valid within bound", i, dir_tab[i].op);
         end
         n_checks++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL dir_result[%0d]: op=%0d got flags=%b res=%h, want flags=%b res=%h",
                     i, dir_tab[i].op, got[W+3:W], got[W-1:0], exp[W+3:W], exp[W-1:0]);
         end
         n_checks++;
         if (lat !== dir_tab[i].lat) begin
            n_fail++;
            $display("FAIL dir_latency[%0d]: op=%0d got %0d, want %0d", i, dir_tab[i].op, lat,
                     dir_tab[i].lat);
         end
         if (dir_tab[i].lat > 1) begin
            n_checks++;
            if (saw_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL dir_busy_ready[%0d]: in_ready seen 1 while busy, want 0", i);
            end
         end
      end
   endtask

   task automatic test_backpressure;
      logic [W+3:0] got, exp;
      int n;
      drive_req(4'd0, 32'd10, 32'd20);
      exp_q.push_back({4'b0000, 32'd30});
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clock); #1;
         n++;
      end
      alu_op    = 4'd1;
      operand_a = 32'd9;
      operand_b = 32'd4;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         got = {result_zero, result_negative, result_carry, result_overflow, result};
         n_checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hs[%0d]: out_valid=%b in_ready=%b, want 1/0", c, out_valid, in_ready);
         end
         n_checks++;
         if (got !== exp_q[0]) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: got %h, want %h", c, got, exp_q[0]);
         end
         @(posedge clock); #1;
      end
      exp = exp_q.pop_front();
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
      got = {result_zero, result_negative, result_carry, result_overflow, result};
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || got !== exp) begin
         n_fail++;
         $display("FAIL bp_idle: in_ready=%b out_valid=%b res=%h, want 1/0 res=%h",
                  in_ready, out_valid, got, exp);
      end
      exp_q.push_back({4'b0010, 32'd5});
      @(posedge clock); #1;
      in_valid = 1'b0;
      got = {result_zero, result_negative, result_carry, result_overflow, result};
      exp = exp_q.pop_front();
      n_checks++;
      if (out_valid !== 1'b1 || got !== exp) begin
         n_fail++;
         $display("FAIL bp_second: out_valid=%b res=%h, want 1 res=%h", out_valid, got, exp);
      end
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset_busy;
      logic [W+3:0] got, exp;
      int lat, seen;
      bit saw_ready, to;
      drive_req(4'd12, 32'd100, 32'd7);
      repeat (9) @(posedge clock);
      #1;
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rb_busy: in_ready=%b out_valid=%b, want 0/0", in_ready, out_valid);
      end
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0) begin
         n_fail++;
         $display("FAIL rb_after: out_valid=%b in_ready=%b res=%h, want 0/1/0",
                  out_valid, in_ready, result);
      end
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         if (out_valid) seen++;
         @(posedge clock); #1;
      end
      n_checks++;
      if (seen !== 0) begin
         n_fail++;
         $display("FAIL rb_no_valid: out_valid seen %0d cycles, want 0", seen);
      end
      drive_req(4'd0, 32'd2, 32'd3);
      exp_q.push_back({4'b0000, 32'd5});
      collect_resp(got, lat, saw_ready, to);
      exp = exp_q.pop_front();
      n_checks++;
      if (to || got !== exp) begin
         n_fail++;
         $display("FAIL rb_add: got %h, want %h (timeout=%b)", got, exp, to);
      end
   endtask

   task automatic test_back_to_back;
      logic [W+3:0] got, exp;
      logic [3:0] op;
      logic [W-1:0] a, b;
      int prev_acc, acc, n;
      prev_acc  = -1;
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         op = 4'($urandom_range(0, 9));
         a  = $urandom;
         b  = $urandom;
         alu_op = op; operand_a = a; operand_b = b; in_valid = 1'b1;
         n = 0;
         while (!in_ready && n < 10) begin
            @(posedge clock); #1;
            n++;
         end
         exp_q.push_back(model(op, a, b));
         acc = cyc;
         @(posedge clock); #1;
         if (prev_acc >= 0) begin
            n_checks++;
            if (acc - prev_acc !== 2) begin
               n_fail++;
               $display("FAIL b2b_spacing[%0d]: got %0d cycles, want 2", k, acc - prev_acc);
            end
         end
         prev_acc = acc;
         got = {result_zero, result_negative, result_carry, result_overflow, result};
         exp = exp_q.pop_front();
         n_checks++;
         if (out_valid !== 1'b1 || got !== exp) begin
            n_fail++;
            $display("FAIL b2b_result[%0d]: op=%0d out_valid=%b got %h, want %h", k, op,
                     out_valid, got, exp);
         end
      end
      in_valid = 1'b0;
      @(posedge clock); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_random;
      logic [W+3:0] got, exp;
      logic [3:0] op;
      logic [W-1:0] a, b;
      int lat, exp_lat;
      bit saw_ready, to;
      for (int k = 0; k < 40; k++) begin
         op = 4'($urandom_range(0, 15));
         a  = ($urandom_range(0, 7) == 0) ? MIN_NEG : $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'd0;
            1:       b = $urandom_range(0, 40);
            2:       b = -$urandom_range(1, 40);
            default: b = $urandom;
         endcase
         exp_lat = (op >= 4'd10 && op <= 4'd13) ? 33 : 1;
         drive_req(op, a, b);
         exp_q.push_back(model(op, a, b));
         collect_resp(got, lat, saw_ready, to);
         exp = exp_q.pop_front();
         n_checks++;
         if (to || got !== exp || lat !== exp_lat) begin
            n_fail++;
            $display("FAIL rand[%0d]: op=%0d a=%h b=%h got %h lat %0d, want %h lat %0d",
                     k, op, a, b, got, lat, exp, exp_lat);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      alu_op    = '0;
      operand_a = '0;
      operand_b = '0;
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_busy();
      test_back_to_back();
      test_random();
      n_checks++;
      if (exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
